// File: rtl/axi_aw_arbiter_pkg.sv
// Package: axi_aw_arbiter_pkg
// Shared types and helpers for the AW-channel arbiter.
//   state_e   : arbiter FSM states (IDLE = free selection, LOCKED = winner held)
//   QOS_W     : width of the AXI AWQOS field
//   MAX_PORTS : upper bound on the requester count handled by the helper functions
//   bin2oh    : binary index -> one-hot vector
//   oh2bin    : one-hot vector -> binary index
package axi_aw_arbiter_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   localparam int QOS_W     = 4;
   localparam int MAX_PORTS = 32;

   function automatic logic [MAX_PORTS-1:0] bin2oh(input int bin);
      logic [MAX_PORTS-1:0] oh;
      oh      = '0;
      oh[bin] = 1'b1;
      return oh;
   endfunction

   // Highest set bit wins; callers only pass true one-hot vectors.
   function automatic int oh2bin(input logic [MAX_PORTS-1:0] oh);
      int bin;
      bin = 0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         if (oh[i]) bin = i;
      end
      return bin;
   endfunction

endpackage

// File: rtl/axi_aw_rr_arbiter.sv
// Module: axi_aw_rr_arbiter
// Purely combinational round-robin pick: the first requesting index at or
// after ptr_i, wrapping from N-1 back to 0.
// Ports:
//   req_i  [N]     request mask
//   ptr_i  [LOG_N] round-robin start position (always < N)
//   any_o          at least one request present
//   bin_o  [LOG_N] winner index (0 when no request)
//   oh_o   [N]     winner one-hot (all zero when no request)
module axi_aw_rr_arbiter
   import axi_aw_arbiter_pkg::*;
#(
   parameter int N     = 7,
   parameter int LOG_N = 3
) (
   input  logic [N-1:0]     req_i,
   input  logic [LOG_N-1:0] ptr_i,
   output logic             any_o,
   output logic [LOG_N-1:0] bin_o,
   output logic [N-1:0]     oh_o
);

   always_comb begin
      oh_o = '0;
      for (int k = 0; k < N; k++) begin
         // Only the first hit in rotated order is kept.
         if ((oh_o == '0) && req_i[(int'(ptr_i) + k) % N]) begin
            oh_o[(int'(ptr_i) + k) % N] = 1'b1;
         end
      end
   end

   assign any_o = |req_i;
   assign bin_o = LOG_N'(oh2bin(MAX_PORTS'(oh_o)));

endmodule

// File: rtl/axi_aw_arbiter.sv
// Module: axi_aw_arbiter
// Round-robin arbiter sharing one AXI AW channel among N_TARG_PORT masters.
// Every AW handshake pushes the winner's {BIN,OH} ID into the write-data
// allocator's ID FIFO; AW is withheld while that FIFO is full.
// Once a winner is presented without a handshake it is locked so the
// outgoing payload stays stable until it is accepted (or the master
// illegally withdraws AWVALID, which simply releases the lock).
// Optional feature macro: AW_QOS_PRIO_EN -- when defined, only the valid
// masters carrying the highest AWQOS compete; round-robin applies among them.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   awpayload_i/awqos_i/awvalid_i, awready_o   per-master AW channel
//   awpayload_o/awqos_o/awvalid_o, awready_i   AW channel toward the slave
//   push_ID_o, ID_o   ID FIFO push strobe and {BIN_ID, OH_ID}
//   grant_FIFO_ID_i   ID FIFO can accept an entry
module axi_aw_arbiter
   import axi_aw_arbiter_pkg::*;
#(
   parameter int N_TARG_PORT  = 7,
   parameter int LOG_N_TARG   = $clog2(N_TARG_PORT),
   parameter int AW_PAYLOAD_W = 64
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic [N_TARG_PORT-1:0][AW_PAYLOAD_W-1:0]   awpayload_i,
   input  logic [N_TARG_PORT-1:0][QOS_W-1:0]          awqos_i,
   input  logic [N_TARG_PORT-1:0]                     awvalid_i,
   output logic [N_TARG_PORT-1:0]                     awready_o,
   output logic [AW_PAYLOAD_W-1:0]                    awpayload_o,
   output logic [QOS_W-1:0]                           awqos_o,
   output logic                                       awvalid_o,
   input  logic                                       awready_i,
   output logic                                       push_ID_o,
   output logic [LOG_N_TARG+N_TARG_PORT-1:0]          ID_o,
   input  logic                                       grant_FIFO_ID_i
);

   state_e                  state_q, state_d;
   logic [LOG_N_TARG-1:0]   rr_ptr_q, rr_ptr_d;
   logic [LOG_N_TARG-1:0]   sel_q, sel_d;

   logic                    rr_any;
   logic [LOG_N_TARG-1:0]   rr_bin;
   logic [N_TARG_PORT-1:0]  rr_oh;

   logic                    win_any;
   logic [LOG_N_TARG-1:0]   win_bin;
   logic [N_TARG_PORT-1:0]  win_oh;

   logic [LOG_N_TARG-1:0]   sel;
   logic [N_TARG_PORT-1:0]  sel_oh;
   logic                    active;
   logic                    hs;

   axi_aw_rr_arbiter #(
      .N     (N_TARG_PORT),
      .LOG_N (LOG_N_TARG)
   ) u_rr_all (
      .req_i (awvalid_i),
      .ptr_i (rr_ptr_q),
      .any_o (rr_any),
      .bin_o (rr_bin),
      .oh_o  (rr_oh)
   );

`ifdef AW_QOS_PRIO_EN
   logic [QOS_W-1:0]        max_qos;
   logic [N_TARG_PORT-1:0]  qos_mask;
   logic                    mq_any;
   logic [LOG_N_TARG-1:0]   mq_bin;
   logic [N_TARG_PORT-1:0]  mq_oh;

   // Highest AWQOS among valid masters, then keep only masters at that level.
   always_comb begin
      max_qos = '0;
      for (int i = 0; i < N_TARG_PORT; i++) begin
         if (awvalid_i[i] && (awqos_i[i] > max_qos)) max_qos = awqos_i[i];
      end
      qos_mask = '0;
      for (int i = 0; i < N_TARG_PORT; i++) begin
         qos_mask[i] = awvalid_i[i] && (awqos_i[i] == max_qos);
      end
   end

   axi_aw_rr_arbiter #(
      .N     (N_TARG_PORT),
      .LOG_N (LOG_N_TARG)
   ) u_rr_qos (
      .req_i (qos_mask),
      .ptr_i (rr_ptr_q),
      .any_o (mq_any),
      .bin_o (mq_bin),
      .oh_o  (mq_oh)
   );

   // The masked set is non-empty whenever any master is valid.
   assign win_any = rr_any;
   assign win_bin = mq_any ? mq_bin : rr_bin;
   assign win_oh  = mq_any ? mq_oh  : rr_oh;
`else
   assign win_any = rr_any;
   assign win_bin = rr_bin;
   assign win_oh  = rr_oh;
`endif

   // Output path: purely combinational from the current selection.
   assign sel    = (state_q == LOCKED) ? sel_q : win_bin;
   assign sel_oh = (state_q == LOCKED) ? N_TARG_PORT'(bin2oh(int'(sel_q))) : win_oh;

   // Nothing is driven while in reset or with no selection to present.
   assign active = rst_n & ((state_q == LOCKED) | win_any);

   assign awvalid_o   = active & awvalid_i[sel] & grant_FIFO_ID_i;
   assign awready_o   = active ? (sel_oh & {N_TARG_PORT{awready_i & grant_FIFO_ID_i}}) : '0;
   assign hs          = awvalid_o & awready_i;
   assign push_ID_o   = hs;
   assign ID_o        = active ? {sel, sel_oh} : '0;
   assign awpayload_o = active ? awpayload_i[sel] : '0;
   assign awqos_o     = active ? awqos_i[sel] : '0;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      rr_ptr_d = rr_ptr_q;

      if (hs) begin
         rr_ptr_d = (sel == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : sel + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (!hs && win_any) begin
               state_d = LOCKED;
               sel_d   = win_bin;
            end
         end
         LOCKED: begin
            // A withdrawn AWVALID is a protocol violation; release rather than hang.
            if (hs || !awvalid_i[sel_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         sel_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         sel_q    <= sel_d;
      end
   end

endmodule
